regfile_writeback_ctrl: RTL and testbench



---
 rtl/regfile_writeback_ctrl.sv | 125 ++++++++++++
 tb/tb_regfile_writeback_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback_ctrl.sv
// Register file write-port arbiter: ALU results win, colliding load results wait in a
// small FIFO, and a per-register pending scoreboard tracks outstanding loads.
module regfile_writeback_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int LQ_DEPTH   = 2
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         alu_valid,
   input  logic [ADDR_WIDTH-1:0]        alu_rd,
   input  logic [DATA_WIDTH-1:0]        alu_data,
   input  logic                         load_valid,
   output logic                         load_ready,
   input  logic [ADDR_WIDTH-1:0]        load_rd,
   input  logic [DATA_WIDTH-1:0]        load_data,
   input  logic                         issue_valid,
   input  logic [ADDR_WIDTH-1:0]        issue_rd,
   output logic                         regwrite,
   output logic [ADDR_WIDTH-1:0]        write_reg,
   output logic [DATA_WIDTH-1:0]        write_data,
   output logic [(2**ADDR_WIDTH)-1:0]   pending,
   output logic                         waw_error
);

   localparam int NREG = 2**ADDR_WIDTH;
   localparam int PW   = $clog2(LQ_DEPTH);
   localparam int CW   = $clog2(LQ_DEPTH + 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(LQ_DEPTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);

   logic [ADDR_WIDTH-1:0] q_rd   [LQ_DEPTH];
   logic [DATA_WIDTH-1:0] q_data [LQ_DEPTH];
   logic [PW-1:0]         head;
   logic [PW-1:0]         tail;
   logic [CW-1:0]         count;

   logic                  load_acc;
   logic                  alu_sel;
   logic                  q_empty;
   logic                  pop;
   logic                  bypass;
   logic                  push;
   logic                  sel_we;
   logic [ADDR_WIDTH-1:0] sel_rd;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  clr_en;
   logic [ADDR_WIDTH-1:0] clr_rd;
   logic [NREG-1:0]       pend_nxt;

   assign load_ready = (count != CNT_FULL);
   assign load_acc   = load_valid && load_ready;
   assign alu_sel    = alu_valid && (alu_rd != '0);
   assign q_empty    = (count == '0);
   assign pop        = !alu_sel && !q_empty;
   assign bypass     = !alu_sel && q_empty && load_acc;
   assign push       = load_acc && !bypass;

   // Selection: ALU, then queue head, then bypass; x0 destinations never write
   always_comb begin
      sel_we   = 1'b0;
      sel_rd   = '0;
      sel_data = '0;
      clr_en   = 1'b0;
      clr_rd   = '0;
      if (alu_sel) begin
         sel_we   = 1'b1;
         sel_rd   = alu_rd;
         sel_data = alu_data;
      end else if (pop) begin
         sel_we   = (q_rd[head] != '0);
         sel_rd   = q_rd[head];
         sel_data = q_data[head];
         clr_en   = 1'b1;
         clr_rd   = q_rd[head];
      end else if (bypass) begin
         sel_we   = (load_rd != '0);
         sel_rd   = load_rd;
         sel_data = load_data;
         clr_en   = 1'b1;
         clr_rd   = load_rd;
      end

      // Issue is applied after the clear so a same-cycle re-issue keeps the bit set
      pend_nxt = pending;
      if (clr_en) pend_nxt[clr_rd] = 1'b0;
      if (issue_valid && (issue_rd != '0)) pend_nxt[issue_rd] = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         regwrite   <= 1'b0;
         write_reg  <= '0;
         write_data <= '0;
         pending    <= '0;
         waw_error  <= 1'b0;
         count      <= '0;
         head       <= '0;
         tail       <= '0;
      end else begin
         regwrite   <= sel_we;
         write_reg  <= sel_rd;
         write_data <= sel_data;
         pending    <= pend_nxt;
         if (alu_sel && pending[alu_rd]) waw_error <= 1'b1;
         if (pop)  head <= head + PTR_ONE;
         if (push) tail <= tail + PTR_ONE;
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // Queue payload carries no reset; validity is owned by count/head/tail
   always_ff @(posedge clock) begin
      if (push) begin
         q_rd[tail]   <= load_rd;
         q_data[tail] <= load_data;
      end
   end

endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
// Bench for regfile_writeback_ctrl: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a queue-based reference model.
module tb_regfile_writeback_ctrl;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int LQ = 2;

   logic          clock = 1'b0;
   logic          reset;
   logic          alu_valid;
   logic [AW-1:0] alu_rd;
   logic [DW-1:0] alu_data;
   logic          load_valid;
   logic          load_ready;
   logic [AW-1:0] load_rd;
   logic [DW-1:0] load_data;
   logic          issue_valid;
   logic [AW-1:0] issue_rd;
   logic          regwrite;
   logic [AW-1:0] write_reg;
   logic [DW-1:0] write_data;
   logic [31:0]   pending;
   logic          waw_error;

   regfile_writeback_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LQ_DEPTH(LQ)) dut (
      .clock(clock), .reset(reset),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .load_valid(load_valid), .load_ready(load_ready), .load_rd(load_rd), .load_data(load_data),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .regwrite(regwrite), .write_reg(write_reg), .write_data(write_data),
      .pending(pending), .waw_error(waw_error)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // Reference model: a list of queued loads plus expected outputs
   typedef struct { logic [AW-1:0] rd; logic [DW-1:0] d; } ent_t;
   ent_t        mq[$];
   logic [31:0] m_pend = '0;
   logic        m_waw = 1'b0;
   logic        m_rw = 1'b0;
   logic [AW-1:0] m_wr = '0;
   logic [DW-1:0] m_wd = '0;

   always @(posedge clock) begin : model
      ent_t e;
      bit acc, bypassed, have_clr;
      logic [AW-1:0] clr;
      if (!reset) begin
         mq.delete();
         m_pend = '0; m_waw = 1'b0; m_rw = 1'b0; m_wr = '0; m_wd = '0;
      end else begin
         acc = load_valid && (mq.size() != LQ);
         bypassed = 1'b0; have_clr = 1'b0; clr = '0;
         m_rw = 1'b0; m_wr = '0; m_wd = '0;
         if (alu_valid && alu_rd != 0) begin
            m_rw = 1'b1; m_wr = alu_rd; m_wd = alu_data;
            if (m_pend[alu_rd]) m_waw = 1'b1;
         end else if (mq.size() > 0) begin
            e = mq.pop_front();
            if (e.rd != 0) begin m_rw = 1'b1; m_wr = e.rd; m_wd = e.d; end
            have_clr = 1'b1; clr = e.rd;
         end else if (acc) begin
            bypassed = 1'b1;
            if (load_rd != 0) begin m_rw = 1'b1; m_wr = load_rd; m_wd = load_data; end
            have_clr = 1'b1; clr = load_rd;
         end
         if (acc && !bypassed) mq.push_back('{rd: load_rd, d: load_data});
         if (have_clr) m_pend[clr] = 1'b0;
         if (issue_valid && issue_rd != 0) m_pend[issue_rd] = 1'b1;
      end
   end

   always @(negedge clock) begin
      if (chk_en) begin
         chk("m_regwrite", {63'd0, regwrite}, {63'd0, m_rw});
         if (m_rw) begin
            chk("m_write_reg", {59'd0, write_reg}, {59'd0, m_wr});
            chk("m_write_data", {32'd0, write_data}, {32'd0, m_wd});
         end
         chk("m_pending", {32'd0, pending}, {32'd0, m_pend});
         chk("m_waw_error", {63'd0, waw_error}, {63'd0, m_waw});
         chk("m_load_ready", {63'd0, load_ready}, {63'd0, 1'(mq.size() != LQ)});
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      alu_valid = 0; load_valid = 0; issue_valid = 0;
   endtask

   task automatic alu(input int rd, input int d);
      alu_valid = 1; alu_rd = AW'(rd); alu_data = DW'(d);
   endtask

   task automatic ld(input int rd, input int d);
      load_valid = 1; load_rd = AW'(rd); load_data = DW'(d);
   endtask

   task automatic iss(input int rd);
      issue_valid = 1; issue_rd = AW'(rd);
   endtask

   task automatic exp_wr(input string name, input int rd, input int d);
      chk({name, "_rw"}, {63'd0, regwrite}, 64'd1);
      chk({name, "_reg"}, {59'd0, write_reg}, 64'(rd));
      chk({name, "_data"}, {32'd0, write_data}, 64'(d));
   endtask

   task automatic exp_nowr(input string name);
      chk({name, "_rw"}, {63'd0, regwrite}, 64'd0);
   endtask

   initial begin
      reset = 0; idle(); alu_rd = 0; alu_data = 0; load_rd = 0; load_data = 0; issue_rd = 0;
      // Reset held with ALU traffic present
      alu(3, 20);
      step(); chk_en = 1'b1;
      step();
      exp_nowr("rst");
      chk("rst_write_reg", {59'd0, write_reg}, 64'd0);
      chk("rst_write_data", {32'd0, write_data}, 64'd0);
      chk("rst_pending", {32'd0, pending}, 64'd0);
      chk("rst_ready", {63'd0, load_ready}, 64'd1);
      chk("rst_waw", {63'd0, waw_error}, 64'd0);
      reset = 1;
      step(); exp_wr("alu_first", 3, 20);

      // ALU and load collide: load waits one cycle
      idle(); alu(1, 30); ld(2, 'hAA);
      step(); exp_wr("coll_alu", 1, 30);
      chk("coll_ready", {63'd0, load_ready}, 64'd1);
      idle();
      step(); exp_wr("coll_load", 2, 'hAA);
      step(); exp_nowr("coll_idle");

      // Queue fills under continuous ALU writes; third load refused
      alu(10, 'h10); ld(21, 'h101);
      step(); exp_wr("fill_a", 10, 'h10);
      chk("fill_ready_a", {63'd0, load_ready}, 64'd1);
      alu(11, 'h11); ld(22, 'h102);
      step(); exp_wr("fill_b", 11, 'h11);
      chk("fill_ready_b", {63'd0, load_ready}, 64'd0);
      alu(12, 'h12); ld(23, 'h103);
      step(); exp_wr("fill_c", 12, 'h12);
      chk("fill_ready_c", {63'd0, load_ready}, 64'd0);
      idle();
      step(); exp_wr("drain_1", 21, 'h101);
      step(); exp_wr("drain_2", 22, 'h102);
      step(); exp_nowr("drain_end");

      // Pending scoreboard around bypassed loads
      iss(5);
      step(); chk("pend_set", {63'd0, pending[5]}, 64'd1);
      idle(); ld(5, 'h55);
      step(); exp_wr("pend_byp", 5, 'h55);
      chk("pend_clr", {63'd0, pending[5]}, 64'd0);
      iss(5);
      step(); chk("pend_reset_set", {63'd0, pending[5]}, 64'd1);
      idle(); ld(5, 'h56); iss(5);
      step(); exp_wr("pend_same", 5, 'h56);
      chk("pend_setwins", {63'd0, pending[5]}, 64'd1);
      idle(); ld(5, 'h57);
      step(); chk("pend_clr2", {63'd0, pending[5]}, 64'd0);

      // x0 destinations
      idle(); alu(0, 20);
      step(); exp_nowr("x0_alu");
      idle(); alu(1, 1); ld(0, 'h99);
      step(); exp_wr("x0_q_alu", 1, 1);
      idle();
      step(); exp_nowr("x0_q_pop");
      chk("x0_ready", {63'd0, load_ready}, 64'd1);
      alu(0, 20); ld(4, 'h44);
      step(); exp_wr("x0_noclaim", 4, 'h44);

      // WAW detection, then reset with queued loads
      idle(); iss(7);
      step();
      idle(); alu(7, 77);
      step(); exp_wr("waw_wr", 7, 77);
      chk("waw_set", {63'd0, waw_error}, 64'd1);
      idle();
      step(); chk("waw_sticky", {63'd0, waw_error}, 64'd1);
      alu(1, 'h1); ld(8, 'h88);
      step();
      alu(2, 'h2); ld(9, 'h99);
      step();
      chk("q2_ready", {63'd0, load_ready}, 64'd0);
      idle(); reset = 0;
      step(); exp_nowr("mrst");
      chk("mrst_waw", {63'd0, waw_error}, 64'd0);
      chk("mrst_ready", {63'd0, load_ready}, 64'd1);
      chk("mrst_pending", {32'd0, pending}, 64'd0);
      reset = 1;
      step(); exp_nowr("mrst_after1");
      step(); exp_nowr("mrst_after2");

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         reset       = ($urandom_range(0, 199) != 0);
         alu_valid   = ($urandom_range(0, 2) == 0);
         alu_rd      = AW'($urandom_range(0, 7));
         alu_data    = $urandom;
         load_valid  = ($urandom_range(0, 1) == 0);
         load_rd     = AW'($urandom_range(0, 7));
         load_data   = $urandom;
         issue_valid = ($urandom_range(0, 2) == 0);
         issue_rd    = AW'($urandom_range(0, 7));
         step();
      end
      reset = 1; idle();
      step(); step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
